// File: rtl/reset_sequencer.sv
// reset_sequencer: asynchronous-assert, synchronized/debounced, staged-release reset tree.
// Revision 1.0 - initial release.
`default_nettype none

module reset_sequencer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STAGE_GAP       = 16
) (
  input  logic       clk_25mhz,
  input  logic       reset_button_n,
  input  logic       sw_rst_req,
  output logic       rst_sys,
  output logic       rst_periph,
  output logic       rst_cpu,
  output logic       running,
  output logic [2:0] state
);

  localparam int CNT_MAX = (DEBOUNCE_CYCLES > STAGE_GAP) ? DEBOUNCE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_SYS      = 3'd2,
    ST_PERIPH   = 3'd3,
    ST_RUN      = 3'd4
  } state_t;

  state_t           cur_state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic             btn_ok;
  logic             sw_take;
  logic             counting;
  logic             nxt_rst_sys, nxt_rst_periph, nxt_rst_cpu, nxt_running;

  assign btn_ok = sync_q[SYNC_STAGES-1];
  assign state  = cur_state;

  always_ff @(posedge clk_25mhz or negedge reset_button_n) begin
    if (!reset_button_n) begin
      sync_q     <= '0;
      cur_state  <= ST_RESET;
      cnt        <= '0;
      rst_sys    <= 1'b1;
      rst_periph <= 1'b1;
      rst_cpu    <= 1'b1;
      running    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      cur_state  <= nxt_state;
      cnt        <= nxt_cnt;
      rst_sys    <= nxt_rst_sys;
      rst_periph <= nxt_rst_periph;
      rst_cpu    <= nxt_rst_cpu;
      running    <= nxt_running;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    sw_take   = 1'b0;
    counting  = 1'b0;

    case (cur_state)
      ST_RESET: begin
        if (btn_ok) nxt_state = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        counting = 1'b1;
        if (cnt == DEB_LAST) nxt_state = ST_SYS;
      end
      ST_SYS: begin
        counting = 1'b1;
        if (cnt == GAP_LAST) nxt_state = ST_PERIPH;
      end
      ST_PERIPH: begin
        counting = 1'b1;
        if (cnt == GAP_LAST) nxt_state = ST_RUN;
      end
      ST_RUN: begin
        nxt_state = ST_RUN;
      end
      default: begin
        nxt_state = ST_RESET;
      end
    endcase

    // Software request wins over any terminal count reached on the same edge.
    if (sw_rst_req && (cur_state inside {ST_DEBOUNCE, ST_SYS, ST_PERIPH, ST_RUN})) begin
      sw_take   = 1'b1;
      nxt_state = ST_DEBOUNCE;
    end

    if (sw_take || (nxt_state != cur_state) || !counting) begin
      nxt_cnt = '0;
    end else begin
      nxt_cnt = cnt + CNT_W'(1);
    end

    // Outputs are registered from the next state so they never glitch.
    nxt_rst_sys    = (nxt_state == ST_RESET) || (nxt_state == ST_DEBOUNCE);
    nxt_rst_periph = !((nxt_state == ST_PERIPH) || (nxt_state == ST_RUN));
    nxt_rst_cpu    = (nxt_state != ST_RUN);
    nxt_running    = (nxt_state == ST_RUN);
  end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed + randomized bench for reset_sequencer against an edge-count model.
// Revision 1.0 - initial release.
`default_nettype none

module tb_reset_sequencer;

  localparam int SYNC = 2;
  localparam int DEB  = 8;
  localparam int GAP  = 4;
  localparam int RESET_PACK = 7'b1110000;

  logic       clk = 1'b0;
  logic       btn = 1'b0;
  logic       sw  = 1'b0;
  logic       rst_sys, rst_periph, rst_cpu, running;
  logic [2:0] state;

  int  errors = 0;
  int  checks = 0;
  int  hi     = 0;
  int  since  = -1;
  bit  cmp_en = 1'b0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .STAGE_GAP      (GAP)
  ) dut (
    .clk_25mhz     (clk),
    .reset_button_n(btn),
    .sw_rst_req    (sw),
    .rst_sys       (rst_sys),
    .rst_periph    (rst_periph),
    .rst_cpu       (rst_cpu),
    .running       (running),
    .state         (state)
  );

  // Model: 'hi' counts edges since the button rose, 'since' counts edges since the
  // sequence (re)entered debounce; all outputs follow arithmetically from 'since'.
  always @(negedge btn) begin
    hi    = 0;
    since = -1;
  end

  always @(posedge clk) begin
    if (btn) begin
      if (since >= 0) begin
        since = sw ? 0 : since + 1;
      end else begin
        hi++;
        if (hi == SYNC + 1) since = 0;
      end
    end
  end

  function automatic int exp_state();
    if (since < 0)             return 0;
    if (since < DEB)           return 1;
    if (since < DEB + GAP)     return 2;
    if (since < DEB + 2 * GAP) return 3;
    return 4;
  endfunction

  function automatic int exp_pack();
    int st;
    st = exp_state();
    return {(st < 2) ? 1'b1 : 1'b0, (st < 3) ? 1'b1 : 1'b0, (st < 4) ? 1'b1 : 1'b0,
            (st == 4) ? 1'b1 : 1'b0, 3'(st)};
  endfunction

  function automatic int dut_pack();
    return {rst_sys, rst_periph, rst_cpu, running, state};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) chk("model", dut_pack(), exp_pack());
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic release_btn();
    @(negedge clk);
    #1 btn = 1'b1;
  endtask

  task automatic glitch();
    @(posedge clk);
    #1 btn = 1'b0;
    #1 chk("glitch_async", dut_pack(), RESET_PACK);
    #2 btn = 1'b1;
  endtask

  task automatic wait_run();
    for (int i = 0; i < 100; i++) begin
      edge1();
      if (running) return;
    end
    chk("wait_run_timeout", 0, 1);
  endtask

  initial begin
    cmp_en = 1'b1;

    // Power-up: button held low, then released.
    repeat (5) @(negedge clk);
    #1 chk("por_low", dut_pack(), RESET_PACK);
    release_btn();
    for (int e = 1; e <= 19; e++) begin
      edge1();
      if (e == 2)  chk("por_e2_state", state, 0);
      if (e == 3)  chk("por_e3_state", state, 1);
      if (e == 10) chk("por_e10_rst_sys", rst_sys, 1);
      if (e == 11) chk("por_e11_rst_sys", rst_sys, 0);
      if (e == 11) chk("por_e11_state", state, 2);
      if (e == 14) chk("por_e14_rst_periph", rst_periph, 1);
      if (e == 15) chk("por_e15_rst_periph", rst_periph, 0);
      if (e == 18) chk("por_e18_running", running, 0);
      if (e == 19) chk("por_e19_run", {rst_cpu, running, state}, 5'b0_1_100);
    end

    // Bounce at edge 6 restarts the sequence.
    btn = 1'b0;
    repeat (2) @(negedge clk);
    release_btn();
    repeat (5) edge1();
    glitch();
    for (int e = 1; e <= 11; e++) begin
      edge1();
      if (e == 10) chk("bounce_e10_rst_sys", rst_sys, 1);
      if (e == 11) chk("bounce_e11_rst_sys", rst_sys, 0);
    end

    // Reset mid-run, asserted between edges.
    wait_run();
    #3 btn = 1'b0;
    #1 chk("midrun_async", dut_pack(), RESET_PACK);
    repeat (3) @(negedge clk);
    release_btn();

    // Software reset from RUN.
    wait_run();
    @(negedge clk);
    #1 sw = 1'b1;
    edge1();
    sw = 1'b0;
    chk("swr_N", {rst_sys, rst_periph, rst_cpu, running}, 4'b1110);
    for (int k = 1; k <= 16; k++) begin
      edge1();
      if (k == 7)  chk("swr_N7_rst_sys", rst_sys, 1);
      if (k == 8)  chk("swr_N8_rst_sys", rst_sys, 0);
      if (k == 11) chk("swr_N11_rst_periph", rst_periph, 1);
      if (k == 12) chk("swr_N12_rst_periph", rst_periph, 0);
      if (k == 15) chk("swr_N15_rst_cpu", rst_cpu, 1);
      if (k == 16) chk("swr_N16_rst_cpu", rst_cpu, 0);
    end

    // Collision: request sampled on the SYS terminal-count edge (edge 15 after release).
    btn = 1'b0;
    repeat (2) @(negedge clk);
    release_btn();
    repeat (14) edge1();
    sw = 1'b1;
    edge1();
    sw = 1'b0;
    chk("collide_state", state, 1);
    chk("collide_rst_sys", rst_sys, 1);

    // Request held through RESET is ignored.
    @(negedge clk);
    #1 btn = 1'b0;
    sw  = 1'b1;
    repeat (3) @(negedge clk);
    release_btn();
    for (int e = 1; e <= 11; e++) begin
      edge1();
      if (e == 2)  sw = 1'b0;
      if (e == 3)  chk("ignore_e3_state", state, 1);
      if (e == 10) chk("ignore_e10_rst_sys", rst_sys, 1);
      if (e == 11) chk("ignore_e11_rst_sys", rst_sys, 0);
    end

    // Randomized traffic: software pulses, glitches and longer button drops.
    for (int i = 0; i < 3000; i++) begin
      int r;
      @(negedge clk);
      #2;
      r = $urandom_range(0, 199);
      if (r < 2) begin
        btn = 1'b0;
        #1 chk("rnd_glitch", dut_pack(), RESET_PACK);
        #1 btn = 1'b1;
      end else if (r < 3) begin
        btn = 1'b0;
        #1 chk("rnd_drop", dut_pack(), RESET_PACK);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        #2 btn = 1'b1;
      end else if (r < 12) begin
        sw = 1'b1;
        @(negedge clk);
        #2 sw = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/reset_sequencer.md
# reset_sequencer

Generates the system reset tree from the raw board reset button. Reset assertion is asynchronous and immediate. Release is synchronized, debounced, and staged so the bus/memory fabric leaves reset first, then peripherals, then the CPU. Sits at the top level between the `reset_button_n` pin and every consumer of reset, including the blink/display test harness. It also accepts a synchronous software reset request from the CPU domain.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for the button release edge; must be ≥2.
- `DEBOUNCE_CYCLES`, 250000: cycles the synchronized button must stay high before release begins (10 ms at 25 MHz); must be ≥1.
- `STAGE_GAP`, 16: cycles between successive staged reset releases; must be ≥1.

Ports:
- `clk_25mhz`  in  1  sole clock.
- `reset_button_n`  in  1  asynchronous, active-low reset (raw button, may bounce); all flops clear asynchronously while low.
- `sw_rst_req`  in  1  synchronous one-cycle software reset request.
- `rst_sys`  out  1  active-high reset for bus/RAM/ROM; released first.
- `rst_periph`  out  1  active-high reset for UART, display and other peripherals; released second.
- `rst_cpu`  out  1  active-high reset for the CPU core; released last.
- `running`  out  1  high only when all resets are released.
- `state`  out  3  debug encoding of the sequencer state, suitable for LEDs.

## Operation
- States and encodings: RESET=0, DEBOUNCE=1, SYS=2, PERIPH=3, RUN=4. Unused encodings return to RESET on the next edge.
- Outputs per state:
  - RESET and DEBOUNCE: `rst_sys`=`rst_periph`=`rst_cpu`=1, `running`=0.
  - SYS: `rst_sys`=0; all other resets 1.
  - PERIPH: `rst_sys`=`rst_periph`=0; `rst_cpu`=1.
  - RUN: all resets 0, `running`=1.
- Async reset (`reset_button_n`=0) forces all of the following immediately, independent of the clock:
  - state=RESET;
  - synchronizer chain, counter and `running` to 0;
  - all three `rst_*` outputs to 1.
- Synchronizer: an `SYNC_STAGES`-deep chain shifting in constant 1, asynchronously cleared by the button. Its last stage is `btn_ok`.
- Counter:
  - One shared counter, width `$clog2(max(DEBOUNCE_CYCLES,STAGE_GAP))+1`.
  - Cleared on every state transition; increments by 1 each cycle otherwise.
  - Never wraps, because every terminal count forces a transition.
- Transitions:
  - RESET→DEBOUNCE when `btn_ok`=1.
  - DEBOUNCE→SYS when count == `DEBOUNCE_CYCLES`−1.
  - SYS→PERIPH when count == `STAGE_GAP`−1.
  - PERIPH→RUN when count == `STAGE_GAP`−1.
  - RUN holds.
- Bounce: any low glitch on `reset_button_n` during any state asynchronously restarts the whole sequence from RESET.
- `sw_rst_req`=1 in DEBOUNCE, SYS, PERIPH or RUN:
  - next edge → DEBOUNCE with counter cleared;
  - all resets reasserted and `running`=0 on that same edge.
- `sw_rst_req` in RESET is ignored. It has priority over a simultaneous terminal-count transition.
- All outputs are driven directly from flops, not decoded combinationally from `state`, so they are glitch-free.

## Timing
- Assertion latency from `reset_button_n` falling: zero clocks (asynchronous).
- Release latency, with edge 1 being the first rising clock after `reset_button_n` rises:
  - `btn_ok`=1 after edge `SYNC_STAGES`.
  - Enter DEBOUNCE at edge `SYNC_STAGES`+1.
  - `rst_sys` falls at edge `SYNC_STAGES`+1+`DEBOUNCE_CYCLES`.
  - `rst_periph` falls `STAGE_GAP` edges after `rst_sys`.
  - `rst_cpu` falls and `running` rises together, `STAGE_GAP` edges after `rst_periph`.
- Software reset: on the edge that samples `sw_rst_req`=1, all resets go to 1. They release again after `DEBOUNCE_CYCLES`, +`STAGE_GAP`, +2·`STAGE_GAP` edges respectively.
- Outputs never change between clock edges except on the asynchronous assertion.

## Test plan
With `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=8, `STAGE_GAP`=4:
- Power-up: hold `reset_button_n`=0 for 5 cycles, then release → all rst=1 and state=0 while low; `rst_sys` falls at edge 11, `rst_periph` at edge 15, `rst_cpu`/`running` at edge 19; state reads 1, 2, 3, 4 in sequence.
- Bounce: release, then pulse `reset_button_n` low for 3 ns mid-cycle at edge 6 → all outputs return to reset state immediately, state=0; full release timing restarts from the next rising edge.
- Reset mid-run: in RUN, drop `reset_button_n` between edges → `rst_sys`/`rst_periph`/`rst_cpu`=1 and `running`=0 before the next edge.
- Software reset: in RUN, pulse `sw_rst_req` for one cycle at edge N → all resets =1 at edge N; `rst_sys`=0 at N+8, `rst_periph`=0 at N+12, `rst_cpu`=0 at N+16.
- Request collision: assert `sw_rst_req` on the SYS cycle where count==3 → enters DEBOUNCE (state=1), not PERIPH; `rst_sys` reasserted.
- Ignored request: hold `sw_rst_req`=1 throughout RESET → no effect; sequence timing is unchanged once the request deasserts before DEBOUNCE.
